i2c_slave_read_word: RTL and testbench

Parametrised I2C slave receive engine. Shifts a DATA_WIDTH-bit word off the bus, one bit per SCL rising edge, with selectable bit order. Flags START/STOP conditions that appear mid-word. Sits between the slave bit-level front end and the slave control FSM; the control FSM issues `enable` and consumes `data`/`finish`.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_slave_read_word_if.sv | 29 ++
 rtl/i2c_edge_detect.sv | 30 +++
 rtl/i2c_slave_read_word.sv | 140 ++++++++++++++
 tb/tb_i2c_slave_read_word.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave word receiver: FSM state encoding and
// the bit-count width helper.
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_DONE
   } state_e;

   // Width needed to hold a count of 0..n inclusive.
   function automatic int unsigned bit_count_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/i2c_slave_read_word_if.sv
// Bus between the receive engine (slave modport) and the control FSM /
// bit-level front end (master modport).
interface i2c_slave_read_word_if
   import i2c_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned CW = bit_count_width(DATA_WIDTH);

   logic                  enable;
   logic                  scl;
   logic                  sda;
   logic [DATA_WIDTH-1:0] data;
   logic                  finish;
   logic                  error;
   logic                  busy;
   logic [CW-1:0]         bit_count;

   modport slave (
      input  enable, scl, sda,
      output data, finish, error, busy, bit_count
   );

   modport master (
      output enable, scl, sda,
      input  data, finish, error, busy, bit_count
   );

endinterface

// File: rtl/i2c_edge_detect.sv
// Registers synchronised SCL/SDA and flags SCL edges and any SDA change.
module i2c_edge_detect (
   input  logic clock,
   input  logic reset_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic sda_change_o
);

   logic scl_last_q;
   logic sda_last_q;

   // Idle bus level is high, so resetting to 1 avoids a false edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scl_last_q <= 1'b1;
         sda_last_q <= 1'b1;
      end else begin
         scl_last_q <= scl_i;
         sda_last_q <= sda_i;
      end
   end

   assign scl_rise_o   = ~scl_last_q & scl_i;
   assign scl_fall_o   = scl_last_q & ~scl_i;
   assign sda_change_o = sda_last_q ^ sda_i;

endmodule

// File: rtl/i2c_slave_read_word.sv
// I2C slave receive engine: shifts one DATA_WIDTH word per SCL rising edge.
// Optional SCL stall timeout enabled by defining I2C_SLAVE_READ_TIMEOUT_EN.
module i2c_slave_read_word
   import i2c_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter bit          MSB_FIRST      = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                 clock,
   input  logic                 reset_n,
   i2c_slave_read_word_if.slave bus
);

   localparam int unsigned CW = bit_count_width(DATA_WIDTH);

   if (DATA_WIDTH < 2 || DATA_WIDTH > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("i2c_slave_read_word: DATA_WIDTH must be 2..32 and TIMEOUT_CYCLES >= 1");
   end

   state_e                state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_d;
   logic [DATA_WIDTH-1:0] shift_first;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CW-1:0]         cnt_q;
   logic                  finish_q;
   logic                  error_q;
   logic                  scl_rise;
   logic                  scl_fall;
   logic                  sda_change;
   logic                  start;
   logic                  timeout;

   i2c_edge_detect u_edge (
      .clock        (clock),
      .reset_n      (reset_n),
      .scl_i        (bus.scl),
      .sda_i        (bus.sda),
      .scl_rise_o   (scl_rise),
      .scl_fall_o   (scl_fall),
      .sda_change_o (sda_change)
   );

   assign start = bus.enable & bus.scl;

   always_comb begin
      shift_d     = '0;
      shift_first = '0;
      if (MSB_FIRST) begin
         shift_d     = {shift_q[DATA_WIDTH-2:0], bus.sda};
         shift_first = {{(DATA_WIDTH-1){1'b0}}, bus.sda};
      end else begin
         shift_d     = {bus.sda, shift_q[DATA_WIDTH-1:1]};
         shift_first = {bus.sda, {(DATA_WIDTH-1){1'b0}}};
      end
   end

`ifdef I2C_SLAVE_READ_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] stall_q;
   logic          in_word;

   assign in_word = (state_q == ST_HIGH) || (state_q == ST_LOW);
   assign timeout = in_word && !(scl_rise || scl_fall) && (stall_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else if (in_word && !(scl_rise || scl_fall)) begin
         stall_q <= stall_q + TW'(1);
      end else begin
         stall_q <= '0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Accepted enable overrides the current state, including DONE: finish is
   // already registered for that cycle, so the completed word still reports.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         finish_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         finish_q <= 1'b0;
         if (start) begin
            error_q <= 1'b0;
            shift_q <= shift_first;
            cnt_q   <= CW'(1);
            state_q <= ST_HIGH;
         end else begin
            unique case (state_q)
               ST_IDLE: ;
               ST_HIGH: begin
                  if (bus.scl && sda_change) begin
                     error_q <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= ST_IDLE;
                  end else if (scl_fall) begin
                     if (cnt_q == CW'(DATA_WIDTH)) begin
                        data_q   <= shift_q;
                        finish_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_DONE;
                     end else begin
                        state_q <= ST_LOW;
                     end
                  end
               end
               ST_LOW: begin
                  if (scl_rise) begin
                     shift_q <= shift_d;
                     cnt_q   <= cnt_q + CW'(1);
                     state_q <= ST_HIGH;
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
            endcase
            if (timeout) begin
               error_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         end
      end
   end

   assign bus.data      = data_q;
   assign bus.finish    = finish_q;
   assign bus.error     = error_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.bit_count = cnt_q;

endmodule

// File: tb/tb_i2c_slave_read_word.sv
// Scoreboard bench for i2c_slave_read_word: an 8-bit MSB-first and a
// 12-bit LSB-first instance share SCL/SDA and have separate enables.
module tb_i2c_slave_read_word;

   localparam int unsigned W0   = 8;
   localparam bit          MSB0 = 1'b1;
   localparam int unsigned W1   = 12;
   localparam bit          MSB1 = 1'b0;

   logic clock = 1'b0;
   logic reset_n;
   logic scl, sda, en0, en1;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] last0 = '0;
   logic [31:0] last1 = '0;

   always #5 clock = ~clock;

   i2c_slave_read_word_if #(.DATA_WIDTH(W0)) b0 ();
   i2c_slave_read_word_if #(.DATA_WIDTH(W1)) b1 ();

   assign b0.scl    = scl;
   assign b0.sda    = sda;
   assign b0.enable = en0;
   assign b1.scl    = scl;
   assign b1.sda    = sda;
   assign b1.enable = en1;

   i2c_slave_read_word #(.DATA_WIDTH(W0), .MSB_FIRST(MSB0), .TIMEOUT_CYCLES(16)) u0 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (b0)
   );

   i2c_slave_read_word #(.DATA_WIDTH(W1), .MSB_FIRST(MSB1), .TIMEOUT_CYCLES(16)) u1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (b1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_data(input int d);
      return (d == 0) ? 32'(b0.data) : 32'(b1.data);
   endfunction
   function automatic logic [31:0] get_bc(input int d);
      return (d == 0) ? 32'(b0.bit_count) : 32'(b1.bit_count);
   endfunction
   function automatic logic [31:0] get_busy(input int d);
      return (d == 0) ? 32'(b0.busy) : 32'(b1.busy);
   endfunction
   function automatic logic [31:0] get_err(input int d);
      return (d == 0) ? 32'(b0.error) : 32'(b1.error);
   endfunction
   function automatic logic [31:0] get_fin(input int d);
      return (d == 0) ? 32'(b0.finish) : 32'(b1.finish);
   endfunction

   // Reference: value of a bus bit sequence under the chosen bit order.
   function automatic logic [31:0] model(input bit bits[$], input bit msb);
      logic [31:0] acc = '0;
      foreach (bits[i]) begin
         if (msb) acc = acc * 2 + 32'(bits[i]);
         else     acc = acc + (32'(bits[i]) << i);
      end
      return acc;
   endfunction

   function automatic void rand_bits(output bit bits[$], input int n);
      bits = {};
      for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
   endfunction

   // One bus bit: 3 cycles low (data set), rise (optional enable), 2 high, fall.
   task automatic clock_bit(input int d, input bit b, input bit start, input int bc);
      @(negedge clock); scl = 1'b0; sda = b;
      @(negedge clock);
      @(negedge clock); scl = 1'b1;
      if (d == 0) en0 = start; else en1 = start;
      @(negedge clock); en0 = 1'b0; en1 = 1'b0;
      chk("bit_count", get_bc(d), 32'(bc));
      chk("busy_in_word", get_busy(d), 32'd1);
      if (start) chk("error_cleared", get_err(d), 32'd0);
      @(negedge clock); scl = 1'b0;
   endtask

   task automatic send_partial(input int d, input bit bits[$]);
      foreach (bits[i]) clock_bit(d, bits[i], i == 0, i + 1);
   endtask

   task automatic send_word(input int d, input bit bits[$]);
      logic [31:0] e;
      e = model(bits, (d == 0) ? MSB0 : MSB1);
      if (d == 0) begin q0.push_back(e); last0 = e; end
      else        begin q1.push_back(e); last1 = e; end
      foreach (bits[i]) clock_bit(d, bits[i], i == 0, i + 1);
      @(negedge clock);
      chk("finish_pulse", get_fin(d), 32'd1);
      chk("busy_in_done", get_busy(d), 32'd1);
      @(negedge clock);
      chk("finish_single", get_fin(d), 32'd0);
      chk("busy_after", get_busy(d), 32'd0);
      chk("bit_count_after", get_bc(d), 32'd0);
   endtask

   // Monitor: every finish pops one expected word.
   always @(negedge clock) begin
      if (b0.finish) begin
         if (q0.size() == 0) chk("unexpected_finish0", 32'd1, 32'd0);
         else chk("word0", 32'(b0.data), q0.pop_front());
      end
      if (b1.finish) begin
         if (q1.size() == 0) chk("unexpected_finish1", 32'd1, 32'd0);
         else chk("word1", 32'(b1.data), q1.pop_front());
      end
   end

   initial begin
      bit bits[$];
      int d;
      reset_n = 1'b0; scl = 1'b1; sda = 1'b1; en0 = 1'b0; en1 = 1'b0;
      repeat (3) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         chk("rst_data", get_data(i), 32'd0);
         chk("rst_finish", get_fin(i), 32'd0);
         chk("rst_error", get_err(i), 32'd0);
         chk("rst_busy", get_busy(i), 32'd0);
         chk("rst_bit_count", get_bc(i), 32'd0);
      end
      reset_n = 1'b1;
      @(negedge clock);

      // enable while SCL low is ignored
      scl = 1'b0; en0 = 1'b1; en1 = 1'b1;
      @(negedge clock); en0 = 1'b0; en1 = 1'b0;
      chk("en_scl_low_busy0", get_busy(0), 32'd0);
      chk("en_scl_low_busy1", get_busy(1), 32'd0);
      chk("en_scl_low_bc0", get_bc(0), 32'd0);
      @(negedge clock); scl = 1'b1;
      @(negedge clock);

      bits = '{1, 0, 1, 0, 0, 1, 0, 1};
      send_word(0, bits);
      bits = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
      send_word(1, bits);

      // START/STOP-like SDA toggle during bit 4 high phase
      bits = '{1, 1, 0};
      send_partial(0, bits);
      @(negedge clock); sda = 1'b1;
      @(negedge clock);
      @(negedge clock); scl = 1'b1;
      @(negedge clock); sda = 1'b0;
      @(negedge clock);
      chk("abort_error", get_err(0), 32'd1);
      chk("abort_busy", get_busy(0), 32'd0);
      chk("abort_bit_count", get_bc(0), 32'd0);
      chk("abort_data_kept", get_data(0), last0);
      @(negedge clock); scl = 1'b0;
      repeat (3) @(negedge clock);
      chk("error_sticky", get_err(0), 32'd1);
      rand_bits(bits, W0);
      send_word(0, bits);

      // restart at bit 5 discards the partial word
      rand_bits(bits, 4);
      send_partial(1, bits);
      rand_bits(bits, W1);
      send_word(1, bits);

      // reset mid-word during bit 6
      rand_bits(bits, 5);
      send_partial(0, bits);
      @(negedge clock); sda = 1'b0;
      @(negedge clock);
      @(negedge clock); scl = 1'b1;
      @(negedge clock); reset_n = 1'b0;
      #1;
      chk("midrst_data", get_data(0), 32'd0);
      chk("midrst_finish", get_fin(0), 32'd0);
      chk("midrst_error", get_err(0), 32'd0);
      chk("midrst_busy", get_busy(0), 32'd0);
      chk("midrst_bit_count", get_bc(0), 32'd0);
      last0 = '0; last1 = '0;
      @(negedge clock); reset_n = 1'b1;
      @(negedge clock);

      // SCL stalled low after bit 3
      rand_bits(bits, 3);
      send_partial(0, bits);
      repeat (40) @(negedge clock);
`ifdef I2C_SLAVE_READ_TIMEOUT_EN
      chk("stall_error", get_err(0), 32'd1);
      chk("stall_busy", get_busy(0), 32'd0);
`else
      chk("stall_error", get_err(0), 32'd0);
      chk("stall_busy", get_busy(0), 32'd1);
`endif

      for (int k = 0; k < 16; k++) begin
         d = int'($urandom_range(0, 1));
         rand_bits(bits, (d == 0) ? W0 : W1);
         send_word(d, bits);
         repeat ($urandom_range(0, 3)) @(negedge clock);
         chk("data_stable", get_data(d), (d == 0) ? last0 : last1);
      end

      repeat (4) @(negedge clock);
      chk("queue0_drained", 32'(q0.size()), 32'd0);
      chk("queue1_drained", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
